// File: rtl/dr_pfreq_queue.sv
// Prefetch-request queue in front of directory_bank: never back-pressures the L2 side,
// drops the oldest buffered request when full. Optional duplicate filter: DR_PFQ_DEDUP_EN.
package dr_pfq_pkg;
  typedef struct packed {
    logic [5:0]  nid;
    logic [4:0]  l2id;
    logic [49:0] paddr;
  } I_l2todr_req_type;
endpackage

module dr_pfreq_queue
  import dr_pfq_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             l2todr_pfreq_valid,
  output logic             l2todr_pfreq_retry,
  input  I_l2todr_req_type l2todr_pfreq,
  output logic             drpfq_pfreq_valid,
  input  logic             drpfq_pfreq_retry,
  output I_l2todr_req_type drpfq_pfreq,
  output logic [4:0]       pfq_count,
  output logic [15:0]      pfq_drop_cnt
);
  localparam int PW = $clog2(ENTRIES);

  I_l2todr_req_type mem [ENTRIES];
  I_l2todr_req_type oreg;
  logic [PW-1:0]    head, tail;
  logic [4:0]       occ, occ_nxt, cnt;
  logic             ov, ov_nxt;
  logic [15:0]      drop_cnt;

  logic out_xfer, load_oreg, fifo_empty, fifo_full;
  logic dup, in_new, pop, bypass, push, drop;

  // Duplicate filter looks at the live FIFO window and the output register,
  // including an output register that is leaving this very cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    dup = 1'b0;
`ifdef DR_PFQ_DEDUP_EN
    if (ov && oreg.paddr[49:6] == l2todr_pfreq.paddr[49:6])
      dup = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      if ((5'(PW'(PW'(i) - head)) < occ) &&
          (mem[i].paddr[49:6] == l2todr_pfreq.paddr[49:6]))
        dup = 1'b1;
    end
`endif
  end

  always_comb begin
    out_xfer   = ov && !drpfq_pfreq_retry;
    load_oreg  = !ov || out_xfer;
    fifo_empty = (occ == 5'd0);
    fifo_full  = (occ == 5'(ENTRIES));
    in_new     = l2todr_pfreq_valid && !dup;
    pop        = load_oreg && !fifo_empty;
    bypass     = load_oreg && fifo_empty && in_new;
    push       = in_new && !bypass;
    drop       = push && fifo_full && !pop;
    occ_nxt    = occ + 5'(push) - 5'(pop) - 5'(drop);
    ov_nxt     = load_oreg ? (pop || bypass) : ov;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      ov       <= 1'b0;
      cnt      <= '0;
      drop_cnt <= '0;
    end else begin
      // A drop discards the head slot, which the tail then overwrites.
      if (pop || drop) head <= head + PW'(1);
      if (push)        tail <= tail + PW'(1);
      occ <= occ_nxt;
      ov  <= ov_nxt;
      cnt <= occ_nxt + 5'(ov_nxt);
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // NOTE: payload storage carries no reset; validity lives only in occ/ov.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= l2todr_pfreq;
    if (pop)
      oreg <= mem[head];
    else if (bypass)
      oreg <= l2todr_pfreq;
  end

  assign l2todr_pfreq_retry = reset;
  assign drpfq_pfreq_valid  = ov;
  assign drpfq_pfreq        = oreg;
  assign pfq_count          = cnt;
  assign pfq_drop_cnt       = drop_cnt;
endmodule

// File: tb/tb_dr_pfreq_queue.sv
// Scoreboard bench for dr_pfreq_queue: a queue-level model of oreg+FIFO checked every cycle.
module tb_dr_pfreq_queue;
  import dr_pfq_pkg::*;

  localparam int ENTRIES = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             l2todr_pfreq_valid = 1'b0;
  logic             l2todr_pfreq_retry;
  I_l2todr_req_type l2todr_pfreq = '0;
  logic             drpfq_pfreq_valid;
  logic             drpfq_pfreq_retry = 1'b0;
  I_l2todr_req_type drpfq_pfreq;
  logic [4:0]       pfq_count;
  logic [15:0]      pfq_drop_cnt;

  int checks = 0;
  int errors = 0;

  I_l2todr_req_type exp_q[$];
  logic [15:0]      m_drop = '0;

  dr_pfreq_queue #(.ENTRIES(ENTRIES)) dut (
    .clk                (clk),
    .reset              (reset),
    .l2todr_pfreq_valid (l2todr_pfreq_valid),
    .l2todr_pfreq_retry (l2todr_pfreq_retry),
    .l2todr_pfreq       (l2todr_pfreq),
    .drpfq_pfreq_valid  (drpfq_pfreq_valid),
    .drpfq_pfreq_retry  (drpfq_pfreq_retry),
    .drpfq_pfreq        (drpfq_pfreq),
    .pfq_count          (pfq_count),
    .pfq_drop_cnt       (pfq_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic I_l2todr_req_type mk(input logic [49:0] pa);
    I_l2todr_req_type r;
    r.paddr = pa;
    r.l2id  = 5'($urandom);
    r.nid   = 6'($urandom);
    return r;
  endfunction

  // Model: state mirrors what the DUT holds now; inputs are stable for the coming edge.
  always @(negedge clk) begin
    int  sz;
    logic xfer, dup;
    if (reset) begin
      exp_q.delete();
      m_drop = '0;
    end else begin
      check("valid", 64'(drpfq_pfreq_valid), 64'(exp_q.size() > 0));
      check("count", 64'(pfq_count), 64'(exp_q.size()));
      check("drops", 64'(pfq_drop_cnt), 64'(m_drop));
      check("retry_out", 64'(l2todr_pfreq_retry), 64'd0);
      if (exp_q.size() > 0) check("data", 64'(drpfq_pfreq), 64'(exp_q[0]));
      sz   = exp_q.size();
      xfer = (sz > 0) && !drpfq_pfreq_retry;
      dup  = 1'b0;
`ifdef DR_PFQ_DEDUP_EN
      foreach (exp_q[i])
        if (exp_q[i].paddr[49:6] == l2todr_pfreq.paddr[49:6]) dup = 1'b1;
`endif
      if (l2todr_pfreq_valid && !dup && sz == ENTRIES + 1 && !xfer) begin
        exp_q.delete(1);
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
      if (xfer) void'(exp_q.pop_front());
      if (l2todr_pfreq_valid && !dup) exp_q.push_back(l2todr_pfreq);
    end
  end

  task automatic cyc(input logic v, input I_l2todr_req_type req, input logic r);
    @(posedge clk);
    #1;
    l2todr_pfreq_valid = v;
    l2todr_pfreq       = req;
    drpfq_pfreq_retry  = r;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, r);
  endtask

  initial begin
    I_l2todr_req_type a, x;
    int bias;

    // Reset state
    #2;
    check("rst_retry", 64'(l2todr_pfreq_retry), 64'd1);
    check("rst_valid", 64'(drpfq_pfreq_valid), 64'd0);
    check("rst_count", 64'(pfq_count), 64'd0);
    check("rst_drops", 64'(pfq_drop_cnt), 64'd0);
    idle(2, 1'b0);
    reset = 1'b0;
    idle(2, 1'b0);

    // Single request, one-cycle latency
    a = mk(50'h0_0000_1234_5640);
    cyc(1'b1, a, 1'b0);
    cyc(1'b0, '0, 1'b0);
    check("lat_valid", 64'(drpfq_pfreq_valid), 64'd1);
    check("lat_data", 64'(drpfq_pfreq), 64'(a));
    cyc(1'b0, '0, 1'b0);
    check("lat_count", 64'(pfq_count), 64'd0);
    idle(2, 1'b0);

    // Ten requests under retry: R9 drops R1
    for (int i = 0; i < 10; i++) cyc(1'b1, mk(50'((i + 16) << 6)), 1'b1);
    cyc(1'b0, '0, 1'b1);
    check("full_drops", 64'(pfq_drop_cnt), 64'd1);
    check("full_count", 64'(pfq_count), 64'(ENTRIES + 1));
    idle(14, 1'b0);

    // Full FIFO, retry drops low for one cycle alongside an arrival: no drop
    for (int i = 0; i < ENTRIES + 1; i++) cyc(1'b1, mk(50'((i + 64) << 6)), 1'b1);
    cyc(1'b1, mk(50'(200 << 6)), 1'b0);
    cyc(1'b0, '0, 1'b1);
    check("tog_drops", 64'(pfq_drop_cnt), 64'd1);
    check("tog_count", 64'(pfq_count), 64'(ENTRIES + 1));
    idle(3, 1'b1);
    idle(14, 1'b0);

    // Reset in the middle of a stream with 5 held
    for (int i = 0; i < 5; i++) cyc(1'b1, mk(50'((i + 300) << 6)), 1'b1);
    cyc(1'b0, '0, 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_valid", 64'(drpfq_pfreq_valid), 64'd0);
    check("async_retry", 64'(l2todr_pfreq_retry), 64'd1);
    check("async_count", 64'(pfq_count), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drpfq_pfreq_retry = 1'b0;
    x = mk(50'h0_0000_0000_ABC0);
    cyc(1'b1, x, 1'b0);
    cyc(1'b0, '0, 1'b0);
    check("post_rst_valid", 64'(drpfq_pfreq_valid), 64'd1);
    check("post_rst_data", 64'(drpfq_pfreq), 64'(x));
    idle(3, 1'b0);

    // Duplicate filter scenario
    cyc(1'b1, mk(50'h1000), 1'b1);
    cyc(1'b1, mk(50'h1010), 1'b1);
    cyc(1'b1, mk(50'h2000), 1'b1);
    cyc(1'b0, '0, 1'b1);
`ifdef DR_PFQ_DEDUP_EN
    check("dedup_count", 64'(pfq_count), 64'd2);
`else
    check("dedup_count", 64'(pfq_count), 64'd3);
`endif
    idle(6, 1'b0);

    // Random traffic over a small address set, alternating retry pressure
    for (int p = 0; p < 8; p++) begin
      bias = (p % 2 == 0) ? 85 : 20;
      for (int i = 0; i < 60; i++)
        cyc(1'($urandom_range(0, 99) < 70),
            mk({41'($urandom_range(0, 11)), 3'($urandom), 6'($urandom)}),
            1'($urandom_range(0, 99) < bias));
    end
    idle(ENTRIES + 6, 1'b0);
    check("end_count", 64'(pfq_count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
